// File: rtl/present_pkg.sv
// PRESENT-80 shared definitions: S-box table, round count, FSM states.
// Imported by the controller, key schedule and datapath S-box layer.
package present_pkg;

  localparam int ROUNDS_DEF = 31;

  // Nibble i of the S-box is the substitute for input i, MSB first.
  localparam logic [63:0] SBOX = 64'hC56B90AD3EF84712;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [5:0] lo;
    lo = {~x, 2'b00};
    return SBOX[lo +: 4];
  endfunction

endpackage

// File: rtl/present_keyupd.sv
// PRESENT-80 key-schedule step: rotate, S-box top nibble,
// XOR the round counter into bits 19:15.
module present_keyupd
  import present_pkg::*;
(
  input  logic [79:0] k,
  input  logic [4:0]  r,
  output logic [79:0] k_next
);

  logic [79:0] t;

  assign t = {k[18:0], k[79:19]};

  assign k_next = {
    sbox4(t[79:76]),
    t[75:20],
    t[19:15] ^ r,
    t[14:0]
  };

endmodule

// File: rtl/present_ctrl.sv
// PRESENT-80 sequencer: handshake, round counter, round-key
// register and datapath strobes.
module present_ctrl
  import present_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF,
  parameter int CW     = 5
) (
  input  logic          CK,
  input  logic          RN,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [79:0]   key_in,
  output logic          start,
  output logic          act,
  output logic          last,
  output logic [79:0]   krnd,
  output logic [CW-1:0] rnd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  state_t      state;
  logic [79:0] k_next;
  logic [4:0]  r5;
  logic        fin;

  assign r5  = 5'(rnd);
  assign fin = (rnd == CW'(ROUNDS));

  present_keyupd u_keyupd (
    .k      (krnd),
    .r      (r5),
    .k_next (k_next)
  );

  assign in_ready  = (state == S_IDLE);
  assign start     = in_valid & in_ready;
  assign act       = (state == S_ROUND);
  assign last      = act & fin;
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state <= S_IDLE;
      rnd   <= '0;
      krnd  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            krnd  <= key_in;
            rnd   <= CW'(1);
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          // the update on the final round is harmless: krnd is unused in DONE
          krnd <= k_next;
          if (fin) begin
            rnd   <= '0;
            state <= S_DONE;
          end else begin
            rnd <= rnd + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_ctrl.sv
// Scoreboard bench for present_ctrl: random keys against a
// behavioural key-schedule model, plus a ROUNDS=3 instance.
module tb_present_ctrl;

  localparam int R = 31;

  logic        CK = 1'b0;
  logic        RN;
  logic        in_valid, in_ready, start, act, last;
  logic        out_valid, out_ready, busy;
  logic [79:0] key_in, krnd;
  logic [4:0]  rnd;

  logic        in_valid3, in_ready3, start3, act3, last3;
  logic        out_valid3, out_ready3, busy3;
  logic [79:0] key_in3, krnd3;
  logic [4:0]  rnd3;

  always #5 CK = ~CK;

  present_ctrl #(.ROUNDS(R), .CW(5)) dut (
    .CK(CK), .RN(RN), .in_valid(in_valid), .in_ready(in_ready),
    .key_in(key_in), .start(start), .act(act), .last(last),
    .krnd(krnd), .rnd(rnd), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  present_ctrl #(.ROUNDS(3), .CW(5)) dut3 (
    .CK(CK), .RN(RN), .in_valid(in_valid3), .in_ready(in_ready3),
    .key_in(key_in3), .start(start3), .act(act3), .last(last3),
    .krnd(krnd3), .rnd(rnd3), .out_valid(out_valid3),
    .out_ready(out_ready3), .busy(busy3)
  );

  typedef struct {
    int          idx;
    logic [79:0] k;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 1000;
  bit          seen_ov = 1'b0;
  logic [79:0] k2;

  task automatic chk(input string n, input logic [79:0] a,
                     input logic [79:0] e);
    vectors++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  // Key schedule written from the cipher definition: arithmetic
  // rotation, table lookup by shifting the S-box word.
  function automatic logic [79:0] model_upd(logic [79:0] k, int r);
    logic [79:0] t;
    logic [63:0] sb;
    int          s;
    sb = 64'hC56B90AD3EF84712;
    t  = (k << 61) | (k >> 19);
    s  = int'((sb >> (4 * (15 - int'(t >> 76)))) & 64'hF);
    t  = (t & ~(80'hF << 76)) | (80'(s) << 76);
    return t ^ (80'(r % 32) << 15);
  endfunction

  task automatic push_model(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    for (int i = 1; i <= R; i++) begin
      exp_q.push_back('{idx: i, k: k});
      k = model_upd(k, i);
    end
  endtask

  always @(negedge CK) begin
    if (RN) begin
      exp_t e;
      if (start) begin
        cyc     = 0;
        seen_ov = 1'b0;
      end else if (cyc < 1000) begin
        cyc++;
      end
      chk("busy", 80'(busy), 80'(!in_ready));
      if (act) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL act_unexpected: got act=1 want no round");
        end else begin
          e = exp_q.pop_front();
          chk("round_cycle", 80'(cyc), 80'(e.idx));
          chk("rnd", 80'(rnd), 80'(e.idx));
          chk("krnd", krnd, e.k);
          chk("last", 80'(last), 80'(e.idx == R));
          if (cyc == 2) k2 = krnd;
        end
      end else begin
        chk("last_idle", 80'(last), 80'(0));
      end
      if (out_valid && !seen_ov) begin
        seen_ov = 1'b1;
        chk("ov_latency", 80'(cyc), 80'(R + 1));
        chk("rounds_left", 80'(exp_q.size()), 80'(0));
        chk("rnd_done", 80'(rnd), 80'(0));
      end
    end
  end

  task automatic send(input logic [79:0] key, input bit noise);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge CK); #1;
      n++;
    end
    if (!in_ready) begin
      vectors++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
      return;
    end
    in_valid = 1'b1;
    key_in   = key;
    push_model(key);
    @(posedge CK); #1;
    in_valid = 1'b0;
    for (int i = 0; i < R; i++) begin
      if (noise) begin
        in_valid  = 1'($urandom);
        out_ready = 1'($urandom);
        key_in    = 80'({$urandom(), $urandom(), $urandom()});
      end
      @(posedge CK); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic complete(input int h);
    for (int i = 0; i < h; i++) begin
      chk("hold_ov", 80'(out_valid), 80'(1));
      chk("hold_act", 80'(act), 80'(0));
      @(posedge CK); #1;
    end
    chk("ov_before_ack", 80'(out_valid), 80'(1));
    out_ready = 1'b1;
    @(posedge CK); #1;
    out_ready = 1'b0;
    chk("idle_ready", 80'(in_ready), 80'(1));
    chk("idle_ov", 80'(out_valid), 80'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    RN        = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    key_in    = '0;
    in_valid3 = 1'b0;
    out_ready3 = 1'b0;
    key_in3   = '0;
    #3;
    chk("rst_in_ready", 80'(in_ready), 80'(1));
    chk("rst_act", 80'(act), 80'(0));
    chk("rst_ov", 80'(out_valid), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_krnd", krnd, 80'(0));
    @(posedge CK); #1;
    RN = 1'b1;

    send(80'h0, 1'b0);
    chk("k2_zero", k2, 80'hC000_0000_0000_0000_8000);
    complete(0);

    send({80{1'b1}}, 1'b1);
    chk("k2_ones", k2, 80'h2FFF_FFFF_FFFF_FFFF_7FFF);
    complete(10);

    in_valid = 1'b1;
    key_in   = 80'({$urandom(), $urandom(), $urandom()});
    push_model(key_in);
    @(posedge CK); #1;
    in_valid = 1'b0;
    repeat (6) begin
      @(posedge CK); #1;
    end
    chk("pre_rst_rnd", 80'(rnd), 80'(7));
    RN = 1'b0;
    #1;
    chk("mid_rst_ready", 80'(in_ready), 80'(1));
    chk("mid_rst_act", 80'(act), 80'(0));
    chk("mid_rst_last", 80'(last), 80'(0));
    chk("mid_rst_rnd", 80'(rnd), 80'(0));
    chk("mid_rst_krnd", krnd, 80'(0));
    exp_q.delete();
    @(posedge CK); #1;
    RN = 1'b1;

    for (int b = 0; b < 6; b++) begin
      send(80'({$urandom(), $urandom(), $urandom()}), 1'($urandom));
      complete(int'($urandom_range(0, 10)));
    end

    @(posedge CK); #1;
    in_valid3 = 1'b1;
    key_in3   = 80'({$urandom(), $urandom(), $urandom()});
    chk("r3_start", 80'(start3), 80'(1));
    @(posedge CK); #1;
    in_valid3 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk("r3_act", 80'(act3), 80'(1));
      chk("r3_last", 80'(last3), 80'(c == 3));
      chk("r3_rnd", 80'(rnd3), 80'(c));
      chk("r3_ov_early", 80'(out_valid3), 80'(0));
      @(posedge CK); #1;
    end
    chk("r3_ov", 80'(out_valid3), 80'(1));
    chk("r3_rnd_done", 80'(rnd3), 80'(0));
    chk("r3_act_done", 80'(act3), 80'(0));
    out_ready3 = 1'b1;
    @(posedge CK); #1;
    out_ready3 = 1'b0;
    chk("r3_idle", 80'(in_ready3), 80'(1));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
